// File: rtl/cisc_pkg.sv
// Shared definitions for the 8-bit CISC accumulator core: opcodes,
// control FSM state encodings, ALU op codes and opcode-class helpers.
package cisc_pkg;

  localparam int ACC_W = 8;

  // Opcode field IR[7:4]; 4'hB..4'hE are undefined.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_ADDR   = 3'd2,
    ST_MEM    = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // ALU op select, shared with the ALU.
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;

  // Instructions followed by an address byte.
  function automatic logic has_operand(input logic [3:0] op);
    return ((op >= OP_LDA) && (op <= OP_XOR)) || (op == OP_JMP) || (op == OP_JZ);
  endfunction

  // Instructions that go on to a data memory access through MAR.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op >= OP_LDA) && (op <= OP_XOR);
  endfunction

  // Two-operand ALU instructions (ADD..XOR).
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hB) && (op <= 4'hE);
  endfunction

  // Map a two-operand ALU opcode onto the ALU op select.
  function automatic logic [2:0] alu_op_of(input logic [3:0] op);
    logic [2:0] sel;
    case (op)
      OP_SUB:  sel = ALU_SUB;
      OP_AND:  sel = ALU_AND;
      OP_OR:   sel = ALU_OR;
      OP_XOR:  sel = ALU_XOR;
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/acc_ctrl_if.sv
// Control bundle between the accumulator control FSM and the datapath /
// memory. The controller takes the master side, the datapath the slave side.
interface acc_ctrl_if;
  logic       mem_ready;
  logic [3:0] ir_op;
  logic       acc_zero;
  logic       mem_rd;
  logic       mem_wr;
  logic       addr_sel;
  logic       ir_ld;
  logic       mar_ld;
  logic       pc_inc;
  logic       pc_ld;
  logic       acc_ld;
  logic       acc_src;
  logic [2:0] alu_op;
  logic       illegal;
  logic       bus_err;
  logic       halted;
  logic [2:0] state;

  modport master (
    input  mem_ready, ir_op, acc_zero,
    output mem_rd, mem_wr, addr_sel, ir_ld, mar_ld, pc_inc, pc_ld,
           acc_ld, acc_src, alu_op, illegal, bus_err, halted, state
  );

  modport slave (
    output mem_ready, ir_op, acc_zero,
    input  mem_rd, mem_wr, addr_sel, ir_ld, mar_ld, pc_inc, pc_ld,
           acc_ld, acc_src, alu_op, illegal, bus_err, halted, state
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Memory wait-state counter. Counts consecutive wait cycles and flags a
// timeout once the count reaches MEM_TIMEOUT (0 disables the timeout).
// The counter saturates rather than wrapping.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_en,
  output logic timeout
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] cnt_q;

  // Count wait cycles; any non-waiting cycle clears the count.
  always_ff @(posedge clk) begin
    if (reset || !wait_en) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout = (MEM_TIMEOUT != 0) && wait_en && (cnt_q == CNT_MAX);

endmodule

// File: rtl/acc_ctrl.sv
// Multi-cycle control FSM for the 8-bit accumulator datapath: sequences
// fetch, decode, operand-address fetch, memory access and accumulator load.
// Moore outputs come from the state; strobes tied to mem_ready are Mealy.
module acc_ctrl
  import cisc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  acc_ctrl_if.master  bus
);

  state_t state_q;
  logic   bus_err_q;
  logic   wait_en;
  logic   timeout;

  // Only the memory-handshake states accumulate wait cycles.
  assign wait_en = ((state_q == ST_FETCH) || (state_q == ST_ADDR) || (state_q == ST_MEM))
                   && !bus.mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .wait_en (wait_en),
    .timeout (timeout)
  );

  // State register and sticky bus error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      bus_err_q <= 1'b0;
    end else if (timeout) begin
      state_q   <= ST_HALT;
      bus_err_q <= 1'b1;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (bus.mem_ready) state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          if (has_operand(bus.ir_op))     state_q <= ST_ADDR;
          else if (bus.ir_op == OP_NOT)   state_q <= ST_EXEC;
          else if (bus.ir_op == OP_HLT)   state_q <= ST_HALT;
          else                            state_q <= ST_FETCH;
        end
        ST_ADDR: begin
          if (bus.mem_ready) begin
            if (is_mem_op(bus.ir_op)) state_q <= ST_MEM;
            else                      state_q <= ST_FETCH;
          end
        end
        ST_MEM: begin
          if (bus.mem_ready) state_q <= ST_FETCH;
        end
        ST_EXEC:  state_q <= ST_FETCH;
        ST_HALT:  state_q <= ST_HALT;
        default:  state_q <= ST_FETCH;
      endcase
    end
  end

  // Output decode; reset and the timeout cycle suppress every strobe.
  always_comb begin
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.addr_sel = 1'b0;
    bus.ir_ld    = 1'b0;
    bus.mar_ld   = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.pc_ld    = 1'b0;
    bus.acc_ld   = 1'b0;
    bus.acc_src  = 1'b0;
    bus.alu_op   = ALU_ADD;
    bus.illegal  = 1'b0;
    bus.halted   = 1'b0;
    bus.bus_err  = bus_err_q && !reset;
    bus.state    = reset ? ST_FETCH : state_q;

    if (reset) begin
      // The reset cycle already presents the fetch request of FETCH.
      bus.mem_rd = 1'b1;
    end else if (!timeout) begin
      case (state_q)
        ST_FETCH: begin
          bus.mem_rd = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_ld  = 1'b1;
            bus.pc_inc = 1'b1;
          end
        end
        ST_DECODE: begin
          bus.illegal = is_illegal(bus.ir_op);
        end
        ST_ADDR: begin
          bus.mem_rd = 1'b1;
          if (bus.mem_ready) begin
            if (is_mem_op(bus.ir_op)) begin
              bus.mar_ld = 1'b1;
              bus.pc_inc = 1'b1;
            end else if ((bus.ir_op == OP_JMP) ||
                         ((bus.ir_op == OP_JZ) && bus.acc_zero)) begin
              bus.pc_ld = 1'b1;
            end else begin
              // Untaken JZ skips over its address byte.
              bus.pc_inc = 1'b1;
            end
          end
        end
        ST_MEM: begin
          bus.addr_sel = 1'b1;
          if (bus.ir_op == OP_STA) bus.mem_wr = 1'b1;
          else                     bus.mem_rd = 1'b1;
          if (bus.mem_ready) begin
            if (bus.ir_op == OP_LDA) begin
              bus.acc_ld = 1'b1;
            end else if (is_alu_op(bus.ir_op)) begin
              bus.acc_ld  = 1'b1;
              bus.acc_src = 1'b1;
              bus.alu_op  = alu_op_of(bus.ir_op);
            end
          end
        end
        ST_EXEC: begin
          bus.acc_ld  = 1'b1;
          bus.acc_src = 1'b1;
          bus.alu_op  = ALU_NOT;
        end
        ST_HALT: begin
          bus.halted = 1'b1;
        end
        default: begin
          bus.mem_rd = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_ctrl.sv
// Directed bench for acc_ctrl: a small PC/IR/MAR/ACC datapath with a
// 256-byte memory wrapped around the controller, plus per-scenario tasks.
module tb_acc_ctrl;
  import cisc_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_ready = 1'b1;
  logic acc_clr = 1'b0;

  logic [7:0] mem [0:255];
  logic [7:0] pc = 8'h00;
  logic [7:0] ir = 8'h00;
  logic [7:0] mar = 8'h00;
  logic [7:0] acc = 8'h00;
  logic [7:0] addr;
  logic [7:0] rdata;

  int n_cmp = 0;
  int n_bad = 0;

  acc_ctrl_if bus();

  acc_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign addr          = bus.addr_sel ? mar : pc;
  assign rdata         = mem[addr];
  assign bus.mem_ready = mem_ready;
  assign bus.ir_op     = ir[7:4];
  assign bus.acc_zero  = (acc == 8'h00);

  function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      default: return a;
    endcase
  endfunction

  // Datapath registers driven by the controller strobes.
  always @(posedge clk) begin
    if (acc_clr)         acc <= 8'h00;
    else if (bus.acc_ld) acc <= bus.acc_src ? alu(bus.alu_op, acc, rdata) : rdata;
    if (reset)           pc <= 8'h00;
    else if (bus.pc_ld)  pc <= rdata;
    else if (bus.pc_inc) pc <= pc + 8'h01;
    if (bus.ir_ld)       ir <= rdata;
    if (bus.mar_ld)      mar <= rdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    acc_clr = 1'b1;
    tick();
    reset = 1'b0;
    acc_clr = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    tick();
    n_cmp++; if (bus.state !== 3'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", bus.state); end
    n_cmp++; if (bus.mem_rd !== 1'b1 || bus.addr_sel !== 1'b0) begin n_bad++; $display("FAIL rst_mem_rd: got rd=%b sel=%b want rd=1 sel=0", bus.mem_rd, bus.addr_sel); end
    n_cmp++; if (bus.ir_ld !== 1'b0 || bus.pc_inc !== 1'b0 || bus.acc_ld !== 1'b0) begin n_bad++; $display("FAIL rst_strobes: got ir_ld=%b pc_inc=%b acc_ld=%b want 0", bus.ir_ld, bus.pc_inc, bus.acc_ld); end
    n_cmp++; if (bus.halted !== 1'b0 || bus.bus_err !== 1'b0 || bus.illegal !== 1'b0) begin n_bad++; $display("FAIL rst_flags: got halted=%b bus_err=%b illegal=%b want 0", bus.halted, bus.bus_err, bus.illegal); end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.ir_ld !== 1'b1 || bus.pc_inc !== 1'b1) begin n_bad++; $display("FAIL fetch_strobes: got ir_ld=%b pc_inc=%b want 1", bus.ir_ld, bus.pc_inc); end
  endtask

  task automatic test_lda();
    n_cmp++; if (bus.state !== 3'd0) begin n_bad++; $display("FAIL lda_c1_state: got %0d want 0", bus.state); end
    tick();
    n_cmp++; if (bus.state !== 3'd1) begin n_bad++; $display("FAIL lda_c2_state: got %0d want 1", bus.state); end
    tick();
    n_cmp++; if (bus.state !== 3'd2 || bus.mar_ld !== 1'b1 || bus.mem_rd !== 1'b1) begin n_bad++; $display("FAIL lda_c3_addr: got state=%0d mar_ld=%b mem_rd=%b want 2/1/1", bus.state, bus.mar_ld, bus.mem_rd); end
    tick();
    n_cmp++; if (bus.state !== 3'd3) begin n_bad++; $display("FAIL lda_c4_state: got %0d want 3", bus.state); end
    n_cmp++; if (bus.acc_ld !== 1'b1 || bus.acc_src !== 1'b0 || bus.addr_sel !== 1'b1) begin n_bad++; $display("FAIL lda_c4_load: got acc_ld=%b acc_src=%b addr_sel=%b want 1/0/1", bus.acc_ld, bus.acc_src, bus.addr_sel); end
    tick();
    n_cmp++; if (bus.state !== 3'd0 || acc !== 8'h1A) begin n_bad++; $display("FAIL lda_result: got state=%0d acc=%h want 0/1a", bus.state, acc); end
  endtask

  task automatic test_add();
    tick();
    tick();
    tick();
    n_cmp++; if (bus.state !== 3'd3 || bus.acc_ld !== 1'b1 || bus.acc_src !== 1'b1 || bus.alu_op !== 3'd0) begin n_bad++; $display("FAIL add_mem: got state=%0d acc_ld=%b acc_src=%b alu_op=%0d want 3/1/1/0", bus.state, bus.acc_ld, bus.acc_src, bus.alu_op); end
    tick();
    n_cmp++; if (acc !== 8'h3C) begin n_bad++; $display("FAIL add_result: got %h want 3c", acc); end
  endtask

  task automatic test_sta_not();
    logic ld_seen;
    ld_seen = bus.acc_ld;
    tick(); ld_seen |= bus.acc_ld;
    tick(); ld_seen |= bus.acc_ld;
    tick(); ld_seen |= bus.acc_ld;
    n_cmp++; if (bus.state !== 3'd3 || bus.mem_wr !== 1'b1 || bus.mem_rd !== 1'b0 || bus.addr_sel !== 1'b1) begin n_bad++; $display("FAIL sta_mem: got state=%0d wr=%b rd=%b sel=%b want 3/1/0/1", bus.state, bus.mem_wr, bus.mem_rd, bus.addr_sel); end
    n_cmp++; if (addr !== 8'h20 || acc !== 8'h3C) begin n_bad++; $display("FAIL sta_data: got addr=%h data=%h want 20/3c", addr, acc); end
    tick(); ld_seen |= bus.acc_ld;
    n_cmp++; if (ld_seen !== 1'b0) begin n_bad++; $display("FAIL sta_no_load: got acc_ld seen=%b want 0", ld_seen); end
    n_cmp++; if (bus.state !== 3'd0) begin n_bad++; $display("FAIL not_c1_state: got %0d want 0", bus.state); end
    tick();
    n_cmp++; if (bus.state !== 3'd1) begin n_bad++; $display("FAIL not_c2_state: got %0d want 1", bus.state); end
    tick();
    n_cmp++; if (bus.state !== 3'd4 || bus.acc_ld !== 1'b1 || bus.acc_src !== 1'b1 || bus.alu_op !== 3'd5) begin n_bad++; $display("FAIL not_exec: got state=%0d acc_ld=%b acc_src=%b alu_op=%0d want 4/1/1/5", bus.state, bus.acc_ld, bus.acc_src, bus.alu_op); end
    tick();
    n_cmp++; if (bus.state !== 3'd0 || acc !== 8'hC3) begin n_bad++; $display("FAIL not_result: got state=%0d acc=%h want 0/c3", bus.state, acc); end
  endtask

  task automatic test_jz();
    mem[8'h00] = 8'hA0; mem[8'h01] = 8'h40;
    mem[8'h40] = 8'h10; mem[8'h41] = 8'h50; mem[8'h50] = 8'h01;
    mem[8'h42] = 8'hA0; mem[8'h43] = 8'h60;
    do_reset();
    tick();
    tick();
    n_cmp++; if (bus.state !== 3'd2 || bus.pc_ld !== 1'b1 || bus.pc_inc !== 1'b0) begin n_bad++; $display("FAIL jz_taken: got state=%0d pc_ld=%b pc_inc=%b want 2/1/0", bus.state, bus.pc_ld, bus.pc_inc); end
    tick();
    n_cmp++; if (bus.state !== 3'd0 || pc !== 8'h40) begin n_bad++; $display("FAIL jz_taken_pc: got state=%0d pc=%h want 0/40", bus.state, pc); end
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (acc !== 8'h01 || pc !== 8'h42) begin n_bad++; $display("FAIL jz_setup: got acc=%h pc=%h want 01/42", acc, pc); end
    tick();
    tick();
    n_cmp++; if (bus.pc_inc !== 1'b1 || bus.pc_ld !== 1'b0) begin n_bad++; $display("FAIL jz_not_taken: got pc_inc=%b pc_ld=%b want 1/0", bus.pc_inc, bus.pc_ld); end
    tick();
    n_cmp++; if (bus.state !== 3'd0 || pc !== 8'h44) begin n_bad++; $display("FAIL jz_not_taken_pc: got state=%0d pc=%h want 0/44", bus.state, pc); end
  endtask

  task automatic test_illegal_halt();
    int stuck;
    mem[8'h00] = 8'hC0; mem[8'h01] = 8'hF0;
    do_reset();
    n_cmp++; if (bus.illegal !== 1'b0) begin n_bad++; $display("FAIL ill_fetch: got %b want 0", bus.illegal); end
    tick();
    n_cmp++; if (bus.state !== 3'd1 || bus.illegal !== 1'b1) begin n_bad++; $display("FAIL ill_decode: got state=%0d illegal=%b want 1/1", bus.state, bus.illegal); end
    tick();
    n_cmp++; if (bus.state !== 3'd0 || bus.illegal !== 1'b0) begin n_bad++; $display("FAIL ill_after: got state=%0d illegal=%b want 0/0", bus.state, bus.illegal); end
    tick();
    tick();
    n_cmp++; if (bus.state !== 3'd5 || bus.halted !== 1'b1 || bus.mem_rd !== 1'b0) begin n_bad++; $display("FAIL hlt_enter: got state=%0d halted=%b mem_rd=%b want 5/1/0", bus.state, bus.halted, bus.mem_rd); end
    stuck = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.halted !== 1'b1 || bus.state !== 3'd5) stuck++;
    end
    n_cmp++; if (stuck != 0) begin n_bad++; $display("FAIL hlt_stay: got %0d cycles out of HALT want 0", stuck); end
  endtask

  task automatic test_timeout();
    mem_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (bus.state !== 3'd0 || bus.mem_rd !== 1'b1 || bus.bus_err !== 1'b0) begin n_bad++; $display("FAIL to_wait%0d: got state=%0d mem_rd=%b bus_err=%b want 0/1/0", k, bus.state, bus.mem_rd, bus.bus_err); end
      tick();
    end
    n_cmp++; if (bus.mem_rd !== 1'b0 || bus.bus_err !== 1'b0 || bus.halted !== 1'b0) begin n_bad++; $display("FAIL to_edge: got mem_rd=%b bus_err=%b halted=%b want 0/0/0", bus.mem_rd, bus.bus_err, bus.halted); end
    tick();
    n_cmp++; if (bus.state !== 3'd5 || bus.halted !== 1'b1 || bus.bus_err !== 1'b1) begin n_bad++; $display("FAIL to_halt: got state=%0d halted=%b bus_err=%b want 5/1/1", bus.state, bus.halted, bus.bus_err); end
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (bus.halted !== 1'b1 || bus.bus_err !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got halted=%b bus_err=%b want 1/1", bus.halted, bus.bus_err); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.bus_err !== 1'b0 || bus.halted !== 1'b0 || bus.state !== 3'd0) begin n_bad++; $display("FAIL to_rst_cycle: got bus_err=%b halted=%b state=%0d want 0/0/0", bus.bus_err, bus.halted, bus.state); end
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.state !== 3'd0 || bus.bus_err !== 1'b0 || bus.halted !== 1'b0) begin n_bad++; $display("FAIL to_recover: got state=%0d bus_err=%b halted=%b want 0/0/0", bus.state, bus.bus_err, bus.halted); end
  endtask

  task automatic test_reset_mid();
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h10; mem[8'h10] = 8'h1A;
    mem[8'h02] = 8'h10; mem[8'h03] = 8'h12; mem[8'h12] = 8'h55;
    mem_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (acc !== 8'h1A) begin n_bad++; $display("FAIL mid_setup: got acc=%h want 1a", acc); end
    tick();
    tick();
    tick();
    n_cmp++; if (bus.state !== 3'd3) begin n_bad++; $display("FAIL mid_in_mem: got %0d want 3", bus.state); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.acc_ld !== 1'b0 || bus.mem_rd !== 1'b1 || bus.mem_wr !== 1'b0 || bus.addr_sel !== 1'b0) begin n_bad++; $display("FAIL mid_rst_cycle: got acc_ld=%b rd=%b wr=%b sel=%b want 0/1/0/0", bus.acc_ld, bus.mem_rd, bus.mem_wr, bus.addr_sel); end
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.state !== 3'd0 || acc !== 8'h1A) begin n_bad++; $display("FAIL mid_after: got state=%0d acc=%h want 0/1a", bus.state, acc); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h10;
    mem[8'h02] = 8'h31; mem[8'h03] = 8'h11;
    mem[8'h04] = 8'h20; mem[8'h05] = 8'h20;
    mem[8'h06] = 8'h80;
    mem[8'h10] = 8'h1A; mem[8'h11] = 8'h22;

    test_reset();
    test_lda();
    test_add();
    test_sta_not();
    test_jz();
    test_illegal_halt();
    test_timeout();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
